// File: rtl/led_seq_pkg.sv
// Shared types and constants for the Avalon LED sequencer.
// The optional readback feature is enabled by defining LED_SEQ_READBACK_EN.
package led_seq_pkg;

    // Sequencer FSM states; READ is only reachable with LED_SEQ_READBACK_EN.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_TICK = 2'd2,
        READ      = 2'd3
    } state_e;

    // Direction of travel of the lit bit in bounce mode.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_WALK   = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_STATIC = 2'd3;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/led_pattern_gen.sv
// Next-pattern logic for the LED sequencer plus the bounce direction register.
// The direction only advances when the parent applies a tick update.
module led_pattern_gen
    import led_seq_pkg::*;
#(
    parameter int LED_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_update,
    input  logic [1:0]       i_mode,
    input  logic [LED_W-1:0] i_pattern,
    input  logic [LED_W-1:0] i_static,
    output logic [LED_W-1:0] o_next
);

    dir_e             r_dir;
    dir_e             w_dir_next;
    logic [LED_W-1:0] w_next;

    // Compute the pattern that follows i_pattern in the selected mode.
    always_comb begin
        w_next     = i_pattern;
        w_dir_next = r_dir;
        case (i_mode)
            MODE_WALK: begin
                if (i_pattern == '0) begin
                    w_next = LED_W'(1);
                end else begin
                    w_next = {i_pattern[LED_W-2:0], i_pattern[LED_W-1]};
                end
            end
            MODE_BOUNCE: begin
                if (i_pattern == '0) begin
                    w_next = LED_W'(1);
                end else if (r_dir == DIR_LEFT) begin
                    // Already at the top end: turn around instead of losing the bit.
                    if (i_pattern[LED_W-1]) begin
                        w_next     = i_pattern >> 1;
                        w_dir_next = DIR_RIGHT;
                    end else begin
                        w_next     = i_pattern << 1;
                        w_dir_next = w_next[LED_W-1] ? DIR_RIGHT : DIR_LEFT;
                    end
                end else begin
                    if (i_pattern[0]) begin
                        w_next     = i_pattern << 1;
                        w_dir_next = DIR_LEFT;
                    end else begin
                        w_next     = i_pattern >> 1;
                        w_dir_next = w_next[0] ? DIR_LEFT : DIR_RIGHT;
                    end
                end
            end
            MODE_COUNT: begin
                w_next = i_pattern + LED_W'(1);
            end
            MODE_STATIC: begin
                w_next = i_static;
            end
            default: begin
                w_next = i_pattern;
            end
        endcase
    end

    // Bounce direction register, advanced together with the pattern register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dir <= DIR_LEFT;
        end else if (i_update) begin
            r_dir <= w_dir_next;
        end
    end

    assign o_next = w_next;

endmodule

// File: rtl/avalon_led_sequencer.sv
// Avalon-MM master that writes timed LED patterns to the PIO data register.
// Define LED_SEQ_READBACK_EN to read every write back and count mismatches.
//
// Handshake: a request (avm_write or avm_read) is held with stable address,
// data and byteenable until a cycle where avm_waitrequest is low; that cycle
// is the transfer, and the request is never withdrawn before it.
module avalon_led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV      = 6250000,
    parameter int LED_W         = 8,
    parameter int ADDR_W        = 4,
    parameter int PIO_DATA_ADDR = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [LED_W-1:0]  static_pattern,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [LED_W-1:0]  pattern_out,
    output logic [7:0]        err_count,
    output state_e            dbg_state
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [LED_W-1:0] r_pattern;
    logic [LED_W-1:0] r_writedata;
    logic [LED_W-1:0] r_pattern_out;
    logic [LED_W-1:0] w_next_pattern;
    logic             r_write;
    logic             w_wr_accept;
    logic             w_tick;
    logic             w_unused_rd;

    // r_write is only ever high while in WRITE.
    assign w_wr_accept = r_write && !avm_waitrequest;
    assign w_tick      = (r_state == WAIT_TICK) && (r_tick_cnt == TICK_LAST);
    assign w_unused_rd = ^avm_readdata;

    led_pattern_gen #(
        .LED_W (LED_W)
    ) u_pattern_gen (
        .i_clk     (clk_clk),
        .i_rst     (reset_reset),
        .i_update  (w_tick),
        .i_mode    (mode),
        .i_pattern (r_pattern),
        .i_static  (static_pattern),
        .o_next    (w_next_pattern)
    );

    // Next-state logic for the sequencer FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = WRITE;
            end
            WRITE: begin
                if (w_wr_accept) begin
`ifdef LED_SEQ_READBACK_EN
                    w_state_next = READ;
`else
                    w_state_next = enable ? WAIT_TICK : IDLE;
`endif
                end
            end
`ifdef LED_SEQ_READBACK_EN
            READ: begin
                if (!avm_waitrequest) w_state_next = enable ? WAIT_TICK : IDLE;
            end
`endif
            WAIT_TICK: begin
                if (!enable)     w_state_next = IDLE;
                else if (w_tick) w_state_next = WRITE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= IDLE;
        else             r_state <= w_state_next;
    end

    // Tick counter: runs only while waiting with enable high, zero otherwise.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_tick_cnt <= '0;
        end else if (r_state == WAIT_TICK && enable && !w_tick) begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end else begin
            r_tick_cnt <= '0;
        end
    end

    // Pattern register advances once per tick.
    always_ff @(posedge clk_clk) begin
        if (reset_reset)  r_pattern <= LED_W'(1);
        else if (w_tick)  r_pattern <= w_next_pattern;
    end

    // Write channel: data is latched on entry to WRITE, the request rises one
    // cycle later and stays up until the slave accepts it.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_write     <= 1'b0;
            r_writedata <= '0;
        end else begin
            if (r_state == IDLE && enable) begin
                r_writedata <= (mode == MODE_STATIC) ? static_pattern : r_pattern;
            end else if (w_tick && enable) begin
                r_writedata <= w_next_pattern;
            end
            if (r_state == WRITE && !r_write) r_write <= 1'b1;
            else if (w_wr_accept)             r_write <= 1'b0;
        end
    end

    // Capture the pattern the slave has accepted.
    always_ff @(posedge clk_clk) begin
        if (reset_reset)      r_pattern_out <= '0;
        else if (w_wr_accept) r_pattern_out <= r_writedata;
    end

`ifdef LED_SEQ_READBACK_EN
    logic [7:0] r_err_count;

    // Saturating count of readbacks that disagree with the accepted pattern.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_err_count <= '0;
        end else if (r_state == READ && !avm_waitrequest &&
                     avm_readdata[LED_W-1:0] != r_pattern_out &&
                     r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign avm_read  = (r_state == READ);
    assign err_count = r_err_count;
`else
    assign avm_read  = 1'b0;
    assign err_count = 8'h00;
`endif

    assign avm_address    = ADDR_W'(PIO_DATA_ADDR);
    assign avm_write      = r_write;
    assign avm_writedata  = 32'(r_writedata);
    assign avm_byteenable = BYTEEN_ALL;
    assign busy           = (r_state != IDLE);
    assign pattern_out    = r_pattern_out;
    assign dbg_state      = r_state;

endmodule
